// File: rtl/fpu_div_arbiter.sv
// Round-robin sharing of one free-running divider between two requesters.
// A tag pipeline that follows the divider returns each quotient to the requester that issued it.

module fpu_div_rsp_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_i,
  input  logic        cap_i,
  input  logic [31:0] cap_data_i,
  input  logic        rsp_ready_i,
  output logic        busy_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        hs_o
);
  logic        busy_q, busy_d;
  logic        vld_q, vld_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    hs_o   = vld_q & rsp_ready_i;
    busy_d = (busy_q | grant_i) & ~hs_o;
    vld_d  = (vld_q & ~hs_o) | cap_i;
    data_d = cap_i ? cap_data_i : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign busy_o      = busy_q;
  assign rsp_valid_o = vld_q;
  assign rsp_data_o  = data_q;
endmodule

module fpu_div_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_out,
  output logic [15:0] ops_done
);
  logic [1:0]        req_vld, elig, grant, busy, hs, cap, rsp_rdy, rsp_vld;
  logic [1:0][31:0]  req_a, req_b, rsp_data;
  logic              last_q, last_d;
  logic [31:0]       div_a_q, div_a_d, div_b_q, div_b_d;
  logic [LAT:0]      tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic [15:0]       ops_done_q, ops_done_d;

  assign req_vld = {req1_valid, req0_valid};
  assign req_a   = {req1_a, req0_a};
  assign req_b   = {req1_b, req0_b};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  // Tag stage 0 rides alongside the div_a/div_b register; stages 1..LAT track the divider.
  always_comb begin
    elig  = req_vld & ~busy;
    grant = '0;
    if (!rst) begin
      grant[0] = elig[0] & (~elig[1] | last_q);
      grant[1] = elig[1] & (~elig[0] | ~last_q);
    end
    last_d     = (|grant) ? grant[1] : last_q;
    div_a_d    = grant[1] ? req_a[1] : (grant[0] ? req_a[0] : div_a_q);
    div_b_d    = grant[1] ? req_b[1] : (grant[0] ? req_b[0] : div_b_q);
    tag_vld_d  = {tag_vld_q[LAT-1:0], |grant};
    tag_id_d   = {tag_id_q[LAT-1:0], grant[1]};
    cap[0]     = tag_vld_q[LAT] & ~tag_id_q[LAT];
    cap[1]     = tag_vld_q[LAT] &  tag_id_q[LAT];
    ops_done_d = ops_done_q + 16'(hs[0]) + 16'(hs[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= 1'b1;
      div_a_q    <= '0;
      div_b_q    <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      ops_done_q <= '0;
    end else begin
      last_q     <= last_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      ops_done_q <= ops_done_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    fpu_div_rsp_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .grant_i    (grant[i]),
      .cap_i      (cap[i]),
      .cap_data_i (div_out),
      .rsp_ready_i(rsp_rdy[i]),
      .busy_o     (busy[i]),
      .rsp_valid_o(rsp_vld[i]),
      .rsp_data_o (rsp_data[i]),
      .hs_o       (hs[i])
    );
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign ops_done   = ops_done_q;
endmodule
